// File: rtl/hp_rd_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin whole-burst grants onto one HP
// slave port, one burst in flight, R beats routed back to the burst owner.
module hp_rd_arbiter #(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic [ID_WIDTH-1:0]   s0_arid,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,

    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic [ID_WIDTH-1:0]   s1_arid,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,

    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic [3:0]            m_arcache,
    output logic [2:0]            m_arprot,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,

    output logic                  o_busy,
    output logic                  o_owner,
    output logic                  o_len_err,
    output logic [1:0]            o_dbg_state
);

    // Handshakes: a transfer happens on any rising clk edge where valid && ready.
    // Valid never waits on ready; the R path is purely combinational.

    localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  len_err_q, len_err_d;

    logic winner;
    logic grant;
    logic rready_sel;
    logic r_beat;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arid_d       = arid_q;
        beat_cnt_d   = beat_cnt_q;
        len_err_d    = 1'b0;
        s0_rvalid    = 1'b0;
        s1_rvalid    = 1'b0;
        rready_sel   = 1'b0;
        r_beat       = 1'b0;

        // Under contention the port that did not win last time goes next.
        winner = (s0_arvalid && s1_arvalid) ? ~last_grant_q : s1_arvalid;
        grant  = (state_q == ST_IDLE) && (s0_arvalid || s1_arvalid);

        s0_arready = grant && !winner;
        s1_arready = grant && winner;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    araddr_d     = winner ? s1_araddr : s0_araddr;
                    arlen_d      = winner ? s1_arlen  : s0_arlen;
                    arid_d       = winner ? s1_arid   : s0_arid;
                    last_grant_d = winner;
                    owner_d      = winner;
                    beat_cnt_d   = 8'd0;
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                rready_sel = owner_q ? s1_rready : s0_rready;
                s0_rvalid  = !owner_q && m_rvalid;
                s1_rvalid  = owner_q && m_rvalid;
                r_beat     = m_rvalid && rready_sel;
                if (r_beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (m_rlast) begin
                        // beat_cnt_q counts beats before this one, so it must equal arlen.
                        len_err_d = (beat_cnt_q != arlen_q);
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arid_q       <= '0;
            beat_cnt_q   <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arid_q       <= arid_d;
            beat_cnt_q   <= beat_cnt_d;
            len_err_q    <= len_err_d;
        end
    end

    assign m_arvalid   = (state_q == ST_ADDR);
    assign m_araddr    = araddr_q;
    assign m_arlen     = arlen_q;
    assign m_arid      = arid_q;
    assign m_arsize    = AR_SIZE;
    assign m_arburst   = 2'b01;
    assign m_arcache   = 4'b0011;
    assign m_arprot    = 3'b000;
    assign m_rready    = rready_sel;

    // Data, resp and last fan out to both ports; only rvalid is qualified by owner.
    assign s0_rdata    = m_rdata;
    assign s0_rresp    = m_rresp;
    assign s0_rlast    = m_rlast;
    assign s1_rdata    = m_rdata;
    assign s1_rresp    = m_rresp;
    assign s1_rlast    = m_rlast;

    assign o_busy      = (state_q != ST_IDLE);
    assign o_owner     = owner_q;
    assign o_len_err   = len_err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_hp_rd_arbiter.sv
// Directed bench for hp_rd_arbiter: expected AR payloads and R beats are queued
// by the drivers and popped by a negedge monitor on every handshake.
module tb_hp_rd_arbiter;
    localparam int AW = 40;
    localparam int DW = 128;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s0_arvalid = 0, s1_arvalid = 0;
    logic          s0_arready, s1_arready;
    logic [AW-1:0] s0_araddr = '0, s1_araddr = '0;
    logic [7:0]    s0_arlen = '0, s1_arlen = '0;
    logic [IW-1:0] s0_arid = '0, s1_arid = '0;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic [1:0]    s0_rresp, s1_rresp;
    logic          s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
    logic          s0_rready = 1'b1, s1_rready = 1'b1;
    logic          m_arvalid;
    logic          m_arready = 1'b1;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [IW-1:0] m_arid;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic [3:0]    m_arcache;
    logic [2:0]    m_arprot;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_rresp = 2'b00;
    logic          m_rlast = 1'b0, m_rvalid = 1'b0;
    logic          m_rready;
    logic          o_busy, o_owner, o_len_err;
    logic [1:0]    o_dbg_state;

    hp_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rstn(rstn),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
        .s0_arlen(s0_arlen), .s0_arid(s0_arid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
        .s1_arlen(s1_arlen), .s1_arid(s1_arid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arid(m_arid), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arcache(m_arcache), .m_arprot(m_arprot), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .o_busy(o_busy), .o_owner(o_owner), .o_len_err(o_len_err), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int r0_cnt  = 0;
    int r1_cnt  = 0;

    logic [AW+8+IW-1:0] ar_q[$];
    logic [DW:0]        r0_q[$];
    logic [DW:0]        r1_q[$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rstn) begin
            check("rvalid_exclusive", 160'(s0_rvalid && s1_rvalid), 160'd0);
            if (m_arvalid && m_arready) begin
                if (ar_q.size() == 0) check("ar_unexpected", 160'(1), 160'(0));
                else check("ar_payload", 160'({m_araddr, m_arlen, m_arid}), 160'(ar_q.pop_front()));
            end
            if (s0_rvalid && s0_rready) begin
                r0_cnt++;
                if (r0_q.size() == 0) check("r0_unexpected", 160'(1), 160'(0));
                else check("r0_beat", 160'({s0_rlast, s0_rdata}), 160'(r0_q.pop_front()));
            end
            if (s1_rvalid && s1_rready) begin
                r1_cnt++;
                if (r1_q.size() == 0) check("r1_unexpected", 160'(1), 160'(0));
                else check("r1_beat", 160'({s1_rlast, s1_rdata}), 160'(r1_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic request(input bit who, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [IW-1:0] id);
        if (who) begin
            s1_arvalid = 1'b1; s1_araddr = addr; s1_arlen = len; s1_arid = id;
        end else begin
            s0_arvalid = 1'b1; s0_araddr = addr; s0_arlen = len; s0_arid = id;
        end
        ar_q.push_back({addr, len, id});
        @(negedge clk);
        check("arready_winner", 160'(who ? s1_arready : s0_arready), 160'd1);
        check("arready_loser", 160'(who ? s0_arready : s1_arready), 160'd0);
        @(posedge clk); #1;
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        @(negedge clk);
        check("m_arvalid_next", 160'(m_arvalid), 160'd1);
    endtask

    task automatic burst(input bit who, input int nbeats, input int last_at, input bit toggle,
                         input bit exp_err, input bit check_end);
        bit hs;
        for (int b = 0; b < nbeats; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = {96'h0, (who ? 32'hB100_0000 : 32'hA000_0000) + 32'(b)};
            m_rlast  = (b == last_at);
            if (who) r1_q.push_back({m_rlast, m_rdata});
            else     r0_q.push_back({m_rlast, m_rdata});
            hs = 1'b0;
            for (int w = 0; w < 20 && !hs; w++) begin
                @(negedge clk);
                if (toggle) check("rready_follows_s0", 160'(m_rready), 160'(s0_rready));
                hs = m_rready;
                @(posedge clk); #1;
                if (toggle) s0_rready = ~s0_rready;
            end
            if (!hs) check("beat_timeout", 160'(0), 160'(1));
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        if (check_end) begin
            @(negedge clk);
            check("len_err_pulse", 160'(o_len_err), 160'(exp_err));
            check("idle_after_last", 160'(o_busy), 160'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("len_err_cleared", 160'(o_len_err), 160'd0);
        end
    endtask

    int r0_before;

    initial begin
        do_reset();

        // reset values and constants
        @(negedge clk);
        check("rst_m_arvalid", 160'(m_arvalid), 160'd0);
        check("rst_payload", 160'({m_araddr, m_arlen, m_arid}), 160'd0);
        check("rst_busy", 160'(o_busy), 160'd0);
        check("rst_owner", 160'(o_owner), 160'd0);
        check("rst_len_err", 160'(o_len_err), 160'd0);
        check("rst_m_rready", 160'(m_rready), 160'd0);
        check("const_ar", 160'({m_arsize, m_arburst, m_arcache, m_arprot}),
              160'({3'd4, 2'b01, 4'b0011, 3'b000}));
        @(posedge clk); #1;

        // single requester, 16-beat burst
        request(1'b0, 40'h10_0000_0000, 8'd15, 4'd2);
        burst(1'b0, 16, 15, 1'b0, 1'b0, 1'b1);
        check("single_owner", 160'(o_owner), 160'd0);

        // AR backpressure then toggling rready on a 4-beat burst
        @(posedge clk); #1;
        m_arready = 1'b0;
        request(1'b0, 40'h00_1234_5670, 8'd3, 4'd5);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("ar_held_valid", 160'(m_arvalid), 160'd1);
            check("ar_held_payload", 160'({m_araddr, m_arlen, m_arid}),
                  160'({40'h00_1234_5670, 8'd3, 4'd5}));
        end
        @(posedge clk); #1;
        m_arready = 1'b1;
        s0_rready = 1'b0;
        r0_before = r0_cnt;
        burst(1'b0, 4, 3, 1'b1, 1'b0, 1'b1);
        check("bp_beat_count", 160'(r0_cnt - r0_before), 160'd4);
        s0_rready = 1'b1;

        // length error: arlen=7, rlast on fifth beat
        @(posedge clk); #1;
        request(1'b1, 40'h20_0000_0040, 8'd7, 4'd9);
        burst(1'b1, 5, 4, 1'b0, 1'b1, 1'b1);

        // stray R data while idle
        @(posedge clk); #1;
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_m_rready", 160'(m_rready), 160'd0);
            check("stray_rvalid", 160'({s0_rvalid, s1_rvalid}), 160'd0);
            check("stray_busy", 160'(o_busy), 160'd0);
            @(posedge clk); #1;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;

        // reset in the middle of a 16-beat burst
        request(1'b0, 40'h00_0000_1000, 8'd15, 4'd7);
        burst(1'b0, 3, 255, 1'b0, 1'b0, 1'b0);
        m_rvalid = 1'b1;
        m_rdata  = 128'hDEAD;
        rstn     = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_m_rready", 160'(m_rready), 160'd0);
        check("midrst_rvalid", 160'({s0_rvalid, s1_rvalid}), 160'd0);
        check("midrst_busy", 160'(o_busy), 160'd0);
        check("midrst_ar", 160'({m_arvalid, m_araddr, m_arlen, m_arid}), 160'd0);
        check("midrst_owner_err", 160'({o_owner, o_len_err}), 160'd0);
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        request(1'b1, 40'h30_0000_0000, 8'd0, 4'd1);
        burst(1'b1, 1, 0, 1'b0, 1'b0, 1'b1);
        check("after_rst_owner", 160'(o_owner), 160'd1);

        // contention out of reset: s0, s1, s0, s1
        do_reset();
        s0_arvalid = 1'b1; s0_araddr = 40'h00_AAAA_0000; s0_arlen = 8'd1; s0_arid = 4'd1;
        s1_arvalid = 1'b1; s1_araddr = 40'h00_BBBB_0000; s1_arlen = 8'd1; s1_arid = 4'd3;
        for (int k = 0; k < 4; k++) begin
            bit exp_who;
            bit got;
            exp_who = k[0];
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge clk);
                got = s0_arready || s1_arready;
                if (!got) @(posedge clk);
            end
            check("rr_grant", 160'({s1_arready, s0_arready}), 160'(exp_who ? 2'b10 : 2'b01));
            ar_q.push_back(exp_who ? {40'h00_BBBB_0000, 8'd1, 4'd3} : {40'h00_AAAA_0000, 8'd1, 4'd1});
            @(posedge clk); #1;
            burst(exp_who, 2, 1, 1'b0, 1'b0, 1'b0);
            check("rr_owner", 160'(o_owner), 160'(exp_who));
        end
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        check("ar_q_drained", 160'(ar_q.size()), 160'd0);
        check("r0_q_drained", 160'(r0_q.size()), 160'd0);
        check("r1_q_drained", 160'(r1_q.size()), 160'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
